// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: opcodes,
// state numbers and the multi-bit datapath select fields.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   typedef enum logic [3:0] {
      ST_IF   = 4'd0,
      ST_ID   = 4'd1,
      ST_MADR = 4'd2,
      ST_MRD  = 4'd3,
      ST_MWB  = 4'd4,
      ST_MWR  = 4'd5,
      ST_REX  = 4'd6,
      ST_RWB  = 4'd7,
      ST_BEQ  = 4'd8,
      ST_JMP  = 4'd9,
      ST_AEX  = 4'd10,
      ST_AWB  = 4'd11,
      ST_BNE  = 4'd12
   } state_e;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Moore main-control FSM for the multi-cycle MIPS datapath.
// Define MC_CTRL_BNE_EN to add BNE decode (state 12) and the PCWriteCondNe port.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W = 6,
   parameter int ST_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic            PCWrite,
   output logic            PCWriteCond,
`ifdef MC_CTRL_BNE_EN
   output logic            PCWriteCondNe,
`endif
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            MemtoReg,
   output logic            RegDst,
   output logic            RegWrite,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      ALUOp,
   output logic [1:0]      PCSource,
   output logic [ST_W-1:0] state,
   output logic            illegal_op
);

   state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IF;
      else      state_q <= state_d;
   end

   assign state = ST_W'(state_q);

   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
`ifdef MC_CTRL_BNE_EN
      PCWriteCondNe = 1'b0;
`endif
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      illegal_op  = 1'b0;

      case (state_q)
         ST_IF: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) state_d = ST_ID;
         end
         ST_ID: begin
            // Speculatively compute the branch target into ALUOut.
            ALUSrcB = SRCB_IMM_SH;
            case (op)
               OP_LW, OP_SW: state_d = ST_MADR;
               OP_RTYPE:     state_d = ST_REX;
               OP_BEQ:       state_d = ST_BEQ;
               OP_J:         state_d = ST_JMP;
               OP_ADDI:      state_d = ST_AEX;
`ifdef MC_CTRL_BNE_EN
               OP_BNE:       state_d = ST_BNE;
`endif
               default: begin
                  state_d    = ST_IF;
                  illegal_op = 1'b1;
               end
            endcase
         end
         ST_MADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            if (op == OP_LW)      state_d = ST_MRD;
            else if (op == OP_SW) state_d = ST_MWR;
            else                  state_d = ST_IF;
         end
         ST_MRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) state_d = ST_MWB;
         end
         ST_MWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            state_d  = ST_IF;
         end
         ST_MWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) state_d = ST_IF;
         end
         ST_REX: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
            state_d = ST_RWB;
         end
         ST_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
            state_d  = ST_IF;
         end
         ST_BEQ: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            state_d     = ST_IF;
         end
         ST_JMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
            state_d  = ST_IF;
         end
         ST_AEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = ST_AWB;
         end
         ST_AWB: begin
            RegWrite = 1'b1;
            state_d  = ST_IF;
         end
`ifdef MC_CTRL_BNE_EN
         ST_BNE: begin
            ALUSrcA       = 1'b1;
            ALUOp         = ALUOP_SUB;
            PCWriteCondNe = 1'b1;
            PCSource      = PCSRC_ALUOUT;
            state_d       = ST_IF;
         end
`endif
         // Encodings with no decode recover to fetch with all strobes low.
         default: state_d = ST_IF;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm; compile with +define+MC_CTRL_BNE_EN to also cover BNE.
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;
`ifdef MC_CTRL_BNE_EN
   logic       PCWriteCondNe;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.OP_W(6), .ST_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .op          (op),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
`ifdef MC_CTRL_BNE_EN
      .PCWriteCondNe (PCWriteCondNe),
`endif
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .RegDst      (RegDst),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .PCSource    (PCSource),
      .state       (state),
      .illegal_op  (illegal_op)
   );

   // Control vector order:
   // PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA | SrcB | ALUOp | PCSrc | illegal
   logic [16:0] ctl;
   assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

   function automatic logic [16:0] exp_ctl(input int st, input bit mr, input bit ill);
      case (st)
         0:  exp_ctl = mr ? 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0
                          : 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
         1:  exp_ctl = {16'b0_0_0_0_0_0_0_0_0_0_11_00_00, ill};
         2:  exp_ctl = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
         3:  exp_ctl = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
         4:  exp_ctl = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
         5:  exp_ctl = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
         6:  exp_ctl = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
         7:  exp_ctl = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
         8:  exp_ctl = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
         9:  exp_ctl = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
         10: exp_ctl = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
         11: exp_ctl = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
         12: exp_ctl = 17'b0_0_0_0_0_0_0_0_0_1_00_01_01_0;
         default: exp_ctl = 17'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are set at the falling edge; sample 1 time unit later.
   task automatic chk_cycle(input string tag, input int st, input bit ill);
      #1;
      chk({tag, "_state"}, 32'(state), 32'(st));
      chk({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl(st, mem_ready, ill)));
      $display("t=%0t %s op=%b mr=%b state=%0d ctl=%b", $time, tag, op, mem_ready, state, ctl);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; op = 6'b000000; mem_ready = 1'b0;
      tick(); tick();
      chk_cycle("reset", 0, 0);
      chk("reset_irwrite", 32'(IRWrite), 32'd0);
      chk("reset_pcwrite", 32'(PCWrite), 32'd0);
      rst = 1'b1;

      // LW with memory always ready: 5 cycles
      op = 6'b100011; mem_ready = 1'b1;
      chk_cycle("lw_if", 0, 0);
      tick(); chk_cycle("lw_id", 1, 0);
      tick(); chk_cycle("lw_madr", 2, 0);
      tick(); chk_cycle("lw_mrd", 3, 0);
      tick(); chk_cycle("lw_mwb", 4, 0);
      tick(); chk_cycle("lw_done", 0, 0);

      // Fetch stall: three cycles not ready, then RTYPE
      op = 6'b000000; mem_ready = 1'b0;
      chk_cycle("stall0", 0, 0);
      tick(); chk_cycle("stall1", 0, 0);
      tick(); chk_cycle("stall2", 0, 0);
      mem_ready = 1'b1;
      chk_cycle("stall_rel", 0, 0);
      tick(); chk_cycle("rt_id", 1, 0);
      tick(); chk_cycle("rt_rex", 6, 0);
      tick(); chk_cycle("rt_rwb", 7, 0);
      tick(); chk_cycle("rt_done", 0, 0);

      // SW with write stalled for two cycles
      op = 6'b101011;
      chk_cycle("sw_if", 0, 0);
      tick(); chk_cycle("sw_id", 1, 0);
      tick(); chk_cycle("sw_madr", 2, 0);
      tick(); mem_ready = 1'b0; chk_cycle("sw_mwr0", 5, 0);
      tick(); chk_cycle("sw_mwr1", 5, 0);
      tick(); mem_ready = 1'b1; chk_cycle("sw_mwr2", 5, 0);
      tick(); chk_cycle("sw_done", 0, 0);

      // Undecoded opcode
      op = 6'b111111;
      chk_cycle("ill_if", 0, 0);
      tick(); chk_cycle("ill_id", 1, 1);
      tick(); chk_cycle("ill_done", 0, 0);

      // BEQ
      op = 6'b000100;
      tick(); chk_cycle("beq_id", 1, 0);
      tick(); chk_cycle("beq_ex", 8, 0);
      tick(); chk_cycle("beq_done", 0, 0);

      // J
      op = 6'b000010;
      tick(); chk_cycle("j_id", 1, 0);
      tick(); chk_cycle("j_jmp", 9, 0);
      tick(); chk_cycle("j_done", 0, 0);

      // ADDI
      op = 6'b001000;
      tick(); chk_cycle("addi_id", 1, 0);
      tick(); chk_cycle("addi_aex", 10, 0);
      tick(); chk_cycle("addi_awb", 11, 0);
      tick(); chk_cycle("addi_done", 0, 0);

      // BNE: new state when enabled, illegal otherwise
      op = 6'b000101;
`ifdef MC_CTRL_BNE_EN
      tick(); chk_cycle("bne_id", 1, 0);
      tick(); chk_cycle("bne_ex", 12, 0);
      chk("bne_condne", 32'(PCWriteCondNe), 32'd1);
      tick(); chk_cycle("bne_done", 0, 0);
      chk("bne_condne_off", 32'(PCWriteCondNe), 32'd0);
`else
      tick(); chk_cycle("bne_id", 1, 1);
      tick(); chk_cycle("bne_done", 0, 0);
`endif

      // Reset asserted in the middle of a memory-read stall
      op = 6'b100011;
      tick(); chk_cycle("rs_id", 1, 0);
      tick(); chk_cycle("rs_madr", 2, 0);
      tick(); mem_ready = 1'b0; chk_cycle("rs_mrd0", 3, 0);
      tick(); chk_cycle("rs_mrd1", 3, 0);
      rst = 1'b0;
      tick(); chk_cycle("rs_reset", 0, 0);
      chk("rs_illegal", 32'(illegal_op), 32'd0);
      rst = 1'b1;
      tick(); chk_cycle("rs_hold_if", 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
